// File: rtl/mem_arbiter.sv
// Two-requester (fetch I, load/store D) arbiter onto one in-order memory port.
// Define MEM_ARBITER_RR_EN for round-robin grant; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int unsigned Xlen           = 32,
    parameter int unsigned MaskBits       = Xlen / 8,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                i_valid_i,
    output logic                i_ready_o,
    input  logic [Xlen-1:0]     i_addr_i,
    input  logic [Xlen-1:0]     i_wdata_i,
    input  logic [MaskBits-1:0] i_wmask_i,
    output logic [Xlen-1:0]     i_rdata_o,
    output logic                i_rvalid_o,

    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [Xlen-1:0]     d_addr_i,
    input  logic [Xlen-1:0]     d_wdata_i,
    input  logic [MaskBits-1:0] d_wmask_i,
    output logic [Xlen-1:0]     d_rdata_o,
    output logic                d_rvalid_o,

    input  logic                mem_ready_i,
    output logic                mem_valid_o,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        ARB_FREE,
        ARB_HOLD_I,
        ARB_HOLD_D
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    owner_e          r_last;
    owner_e          w_gnt;
    owner_e          r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_gnt_valid;
    logic            w_accept;
    logic            w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Fullness comes from the registered count only; a same-cycle pop does not free a slot.
    assign w_full  = (r_count == CntW'(MaxOutstanding));
    assign w_empty = (r_count == '0);

    assign i_rdata_o = mem_rdata_i;
    assign d_rdata_o = mem_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_gnt       = OWN_I;
        w_gnt_valid = 1'b0;
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        mem_valid_o = 1'b0;
        i_ready_o   = 1'b0;
        d_ready_o   = 1'b0;
        mem_addr_o  = i_addr_i;
        mem_wdata_o = i_wdata_i;
        mem_wmask_o = i_wmask_i;

        case (r_state)
            ARB_HOLD_I: w_gnt = OWN_I;
            ARB_HOLD_D: w_gnt = OWN_D;
            default: begin
`ifdef MEM_ARBITER_RR_EN
                if (d_valid_i && i_valid_i) begin
                    w_gnt = (r_last == OWN_D) ? OWN_I : OWN_D;
                end else if (d_valid_i) begin
                    w_gnt = OWN_D;
                end
`else
                if (d_valid_i) begin
                    w_gnt = OWN_D;
                end
`endif
            end
        endcase

        if (w_gnt == OWN_D) begin
            w_gnt_valid = d_valid_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wmask_o = d_wmask_i;
        end else begin
            w_gnt_valid = i_valid_i;
        end

        if (!rst_i && !w_full) begin
            mem_valid_o = w_gnt_valid;
            i_ready_o   = (w_gnt == OWN_I) && mem_ready_i;
            d_ready_o   = (w_gnt == OWN_D) && mem_ready_i;
        end

        w_accept = mem_valid_o && mem_ready_i;

        // A held grant is also released if its owner withdraws, so the other side cannot deadlock.
        case (r_state)
            ARB_FREE: begin
                if (mem_valid_o && !mem_ready_i) begin
                    w_state_nxt = (w_gnt == OWN_D) ? ARB_HOLD_D : ARB_HOLD_I;
                end
            end
            ARB_HOLD_I: begin
                if (w_accept || !i_valid_i) begin
                    w_state_nxt = ARB_FREE;
                end
            end
            ARB_HOLD_D: begin
                if (w_accept || !d_valid_i) begin
                    w_state_nxt = ARB_FREE;
                end
            end
            default: w_state_nxt = ARB_FREE;
        endcase
    end

    always_comb begin
        w_pop      = mem_rvalid_i && !w_empty && !rst_i;
        i_rvalid_o = w_pop && (r_fifo[r_rptr] == OWN_I);
        d_rvalid_o = w_pop && (r_fifo[r_rptr] == OWN_D);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= OWN_I;
            for (int unsigned k = 0; k < MaxOutstanding; k++) begin
                r_fifo[k] <= OWN_I;
            end
        end else begin
            if (w_accept) begin
                r_fifo[r_wptr] <= w_gnt;
                r_wptr         <= ptr_inc(r_wptr);
                r_last         <= w_gnt;
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: ;
            endcase
        end
    end

    spurious_rsp_dropped: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_rvalid_i && w_empty))
        else $warning("mem_arbiter: response with no outstanding request dropped");

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned MB   = 4;
    localparam int unsigned MAXO = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            iv, dv;
    logic [XLEN-1:0] ia, iw, da, dw;
    logic [MB-1:0]   im, dm;
    logic            mem_ready, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            w_i_ready, w_d_ready, w_i_rvalid, w_d_rvalid, w_mem_valid;
    logic [XLEN-1:0] w_i_rdata, w_d_rdata, w_mem_addr, w_mem_wdata;
    logic [MB-1:0]   w_mem_wmask;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: owner queue, pending stalled grant, last granted owner (1 = D).
    bit q[$];
    bit m_locked;
    bit m_lock_own;
    bit m_last;

    bit acc, own;

    always #5 clk = ~clk;

    mem_arbiter #(
        .Xlen(XLEN),
        .MaskBits(MB),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .i_valid_i(iv),
        .i_ready_o(w_i_ready),
        .i_addr_i(ia),
        .i_wdata_i(iw),
        .i_wmask_i(im),
        .i_rdata_o(w_i_rdata),
        .i_rvalid_o(w_i_rvalid),
        .d_valid_i(dv),
        .d_ready_o(w_d_ready),
        .d_addr_i(da),
        .d_wdata_i(dw),
        .d_wmask_i(dm),
        .d_rdata_o(w_d_rdata),
        .d_rvalid_o(w_d_rvalid),
        .mem_ready_i(mem_ready),
        .mem_valid_o(w_mem_valid),
        .mem_addr_o(w_mem_addr),
        .mem_wdata_o(w_mem_wdata),
        .mem_wmask_o(w_mem_wmask),
        .mem_rdata_i(mem_rdata),
        .mem_rvalid_i(mem_rvalid)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked   = 1'b0;
        m_lock_own = 1'b0;
        m_last     = 1'b0;
    endtask

    task automatic idle();
        iv = 1'b0; dv = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    // Check outputs for the current inputs, then advance one clock and update the model.
    task automatic step(output bit acc_o, output bit own_o);
        bit full, gown, gv, exp_mv, pop;
        #4;
        full = (q.size() >= MAXO);
        if (m_locked) begin
            gown = m_lock_own;
        end else begin
`ifdef MEM_ARBITER_RR_EN
            if (iv && dv) gown = !m_last;
            else          gown = dv;
`else
            gown = dv;
`endif
        end
        gv     = gown ? dv : iv;
        exp_mv = !full && gv;
        check_val("mem_valid", w_mem_valid, exp_mv);
        if (exp_mv) begin
            check_val("mem_addr",  w_mem_addr,  gown ? da : ia);
            check_val("mem_wdata", w_mem_wdata, gown ? dw : iw);
            check_val("mem_wmask", w_mem_wmask, gown ? dm : im);
        end
        check_val("i_ready", w_i_ready, !full && !gown && mem_ready);
        check_val("d_ready", w_d_ready, !full &&  gown && mem_ready);
        pop = mem_rvalid && (q.size() > 0);
        check_val("i_rvalid", w_i_rvalid, pop && (q[0] == 1'b0));
        check_val("d_rvalid", w_d_rvalid, pop && (q[0] == 1'b1));
        if (pop) begin
            check_val("i_rdata", w_i_rdata, mem_rdata);
            check_val("d_rdata", w_d_rdata, mem_rdata);
        end
        acc_o = exp_mv && mem_ready;
        own_o = gown;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc_o) begin
            q.push_back(gown);
            m_last   = gown;
            m_locked = 1'b0;
        end else if (exp_mv) begin
            m_locked   = 1'b1;
            m_lock_own = gown;
        end
    endtask

    task automatic drain();
        iv = 1'b0; dv = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = (q.size() > 0);
            mem_rdata  = $urandom;
            step(acc, own);
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        idle();
        ia = '0; iw = '0; im = '0; da = '0; dw = '0; dm = '0; mem_rdata = '0;
        model_reset();

        // Outputs held low during reset even with every input asserted.
        iv = 1'b1; dv = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1;
        #2;
        check_val("rst_mem_valid", w_mem_valid, 0);
        check_val("rst_i_ready",   w_i_ready,   0);
        check_val("rst_d_ready",   w_d_ready,   0);
        check_val("rst_i_rvalid",  w_i_rvalid,  0);
        check_val("rst_d_rvalid",  w_d_rvalid,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // I read alone.
        iv = 1'b1; ia = 32'h100; iw = '0; im = '0; mem_ready = 1'b1;
        #2 check_val("iread_addr", w_mem_addr, 32'h100);
        step(acc, own);
        iv = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        #2;
        check_val("iread_rvalid", w_i_rvalid, 1);
        check_val("iread_rdata",  w_i_rdata,  32'h00500093);
        check_val("iread_drv",    w_d_rvalid, 0);
        step(acc, own);
        mem_rvalid = 1'b0;

        // D read alone.
        dv = 1'b1; da = 32'h2000; dw = '0; dm = '0; mem_ready = 1'b1;
        #2 check_val("dread_addr", w_mem_addr, 32'h2000);
        step(acc, own);
        dv = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #2;
        check_val("dread_rvalid", w_d_rvalid, 1);
        check_val("dread_irv",    w_i_rvalid, 0);
        step(acc, own);
        mem_rvalid = 1'b0;

        // Contention; last grant is D at this point.
        iv = 1'b1; ia = 32'h300; dv = 1'b1; da = 32'h2004; mem_ready = 1'b1;
`ifdef MEM_ARBITER_RR_EN
        #2 check_val("cont_first", w_mem_addr, 32'h300);
        step(acc, own);
        iv = 1'b0;
        #2 check_val("cont_second", w_mem_addr, 32'h2004);
        step(acc, own);
        dv = 1'b0;
`else
        #2 check_val("cont_first", w_mem_addr, 32'h2004);
        step(acc, own);
        dv = 1'b0;
        #2 check_val("cont_second", w_mem_addr, 32'h300);
        step(acc, own);
        iv = 1'b0;
`endif
        drain();

        // Lock hold: I stalled 3 cycles, D arrives on the second.
        iv = 1'b1; ia = 32'h400; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin dv = 1'b1; da = 32'h2008; end
            #2;
            check_val("lock_addr",   w_mem_addr, 32'h400);
            check_val("lock_dready", w_d_ready,  0);
            step(acc, own);
        end
        mem_ready = 1'b1;
        #2 check_val("lock_release", w_mem_addr, 32'h400);
        step(acc, own);
        iv = 1'b0;
        step(acc, own);
        dv = 1'b0;
        drain();

        // Full FIFO: D then I accepted, third request blocked until a response frees a slot.
        mem_ready = 1'b1;
        dv = 1'b1; da = 32'h2010;
        step(acc, own);
        dv = 1'b0; iv = 1'b1; ia = 32'h500;
        step(acc, own);
        ia = 32'h504;
        #2;
        check_val("full_valid",  w_mem_valid, 0);
        check_val("full_iready", w_i_ready,   0);
        step(acc, own);
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
        #2;
        check_val("full_pop_d",   w_d_rvalid,  1);
        check_val("full_nobypass", w_mem_valid, 0);
        step(acc, own);
        mem_rvalid = 1'b0;
        #2 check_val("full_accept", w_mem_valid, 1);
        step(acc, own);
        iv = 1'b0;
        drain();

        // In-order D, I, D with overlapping responses.
        mem_ready = 1'b1;
        dv = 1'b1; da = 32'h2020;
        step(acc, own);
        dv = 1'b0; iv = 1'b1; ia = 32'h600; mem_rvalid = 1'b1;
        #2 check_val("order_1_d", w_d_rvalid, 1);
        step(acc, own);
        iv = 1'b0; dv = 1'b1; da = 32'h2024;
        #2 check_val("order_2_i", w_i_rvalid, 1);
        step(acc, own);
        dv = 1'b0;
        #2 check_val("order_3_d", w_d_rvalid, 1);
        step(acc, own);
        mem_rvalid = 1'b0;

        // Reset with two outstanding; later responses are spurious.
        iv = 1'b1; ia = 32'h700;
        step(acc, own);
        ia = 32'h704;
        step(acc, own);
        iv = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        #2 check_val("midrst_valid", w_mem_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mem_rvalid = 1'b1;
        #2;
        check_val("spur_irv", w_i_rvalid, 0);
        check_val("spur_drv", w_d_rvalid, 0);
        step(acc, own);
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        iv = 1'b1; ia = 32'h800;
        step(acc, own);
        ia = 32'h804;
        #2 check_val("post_rst_empty", w_mem_valid, 1);
        step(acc, own);
        iv = 1'b0;
        drain();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!iv && $urandom_range(0, 2) == 0) begin
                iv = 1'b1; ia = $urandom; iw = $urandom; im = MB'($urandom);
            end
            if (!dv && $urandom_range(0, 2) == 0) begin
                dv = 1'b1; da = $urandom; dw = $urandom; dm = MB'($urandom);
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            step(acc, own);
            if (acc) begin
                if (own) dv = 1'b0;
                else     iv = 1'b0;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
